// File: rtl/pattern_gen_pkg.sv
// Shared constants and per-mode generator math for the 32-bit pattern generator.
// The write-test checker imports this package so both sides agree on seeds and sequences.
package pattern_gen_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] MODE_COUNT = 3'd0;
    localparam logic [2:0] MODE_WALK  = 3'd1;
    localparam logic [2:0] MODE_LFSR  = 3'd2;
    localparam logic [2:0] MODE_ALT   = 3'd3;
    localparam logic [2:0] MODE_ONES  = 3'd4;

    localparam logic [31:0] SEED_ZERO    = 32'h0000_0000;
    localparam logic [31:0] SEED_WALK    = 32'h0000_0001;
    localparam logic [31:0] SEED_ALT     = 32'hAAAA_AAAA;
    localparam logic [31:0] SEED_ONES    = 32'hFFFF_FFFF;
    localparam logic [15:0] LFSR_SEED_LO = 16'hACE1;

    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    function automatic logic mode_valid(input logic [2:0] mode);
        return mode <= MODE_ONES;
    endfunction

    // The fixed low half keeps the LFSR out of its all-zero lock-up state.
    function automatic logic [31:0] seed_value(input logic [2:0] mode, input logic [15:0] seed_hi);
        logic [31:0] seed;
        case (mode)
            MODE_COUNT: seed = SEED_ZERO;
            MODE_WALK:  seed = SEED_WALK;
            MODE_LFSR:  seed = {seed_hi, LFSR_SEED_LO};
            MODE_ALT:   seed = SEED_ALT;
            MODE_ONES:  seed = SEED_ONES;
            default:    seed = SEED_ZERO;
        endcase
        return seed;
    endfunction

    function automatic logic [31:0] next_value(input logic [2:0] mode, input logic [31:0] cur);
        logic [31:0] nxt;
        case (mode)
            MODE_COUNT: nxt = cur + 32'd1;
            MODE_WALK:  nxt = {cur[30:0], cur[31]};
            MODE_LFSR:  nxt = {cur[30:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]
                                        ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
            MODE_ALT:   nxt = ~cur;
            MODE_ONES:  nxt = cur;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pattern_gen_32bit_next.sv
// Combinational seed and next-value logic for every generator mode.
module pattern_next_value
    import pattern_gen_pkg::*;
(
    input  logic [2:0]        run_mode,
    input  logic [WORD_W-1:0] current,
    input  logic [2:0]        load_mode,
    input  logic [15:0]       seed_hi,
    output logic [WORD_W-1:0] next,
    output logic [WORD_W-1:0] seed
);

    always_comb begin
        next = next_value(run_mode, current);
        seed = seed_value(load_mode, seed_hi);
    end

endmodule

// File: rtl/pattern_gen_32bit.sv
// Configurable 32-bit test-word generator feeding a FIFO write port.
// A new config on the wire-in forces a reload; word_count runs across reloads.
module pattern_gen_32bit
    import pattern_gen_pkg::*;
(
    input  logic              okClk,
    input  logic              reset,
    input  logic [31:0]       pattern,
    input  logic              enable_gener,
    output logic [WORD_W-1:0] dataout,
    output logic              dataout_available,
    output logic [31:0]       word_count,
    output logic              mode_error
);

    logic [1:0]        state;
    logic [31:0]       pattern_q;
    logic [WORD_W-1:0] gen;
    logic [WORD_W-1:0] gen_next;
    logic [WORD_W-1:0] gen_seed;

    pattern_next_value u_next (
        .run_mode  (pattern_q[2:0]),
        .current   (gen),
        .load_mode (pattern[2:0]),
        .seed_hi   (pattern[31:16]),
        .next      (gen_next),
        .seed      (gen_seed)
    );

    // A reserved mode leaves the FSM in RUN but suppresses every write strobe.
    always_ff @(posedge okClk) begin
        if (reset) begin
            state             <= ST_IDLE;
            pattern_q         <= '0;
            gen               <= '0;
            dataout           <= '0;
            dataout_available <= 1'b0;
            word_count        <= '0;
            mode_error        <= 1'b0;
        end else begin
            dataout_available <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    pattern_q  <= pattern;
                    gen        <= gen_seed;
                    mode_error <= ~mode_valid(pattern[2:0]);
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (pattern != pattern_q) begin
                        state <= ST_LOAD;
                    end else if (enable_gener && !mode_error) begin
                        dataout           <= gen;
                        dataout_available <= 1'b1;
                        gen               <= gen_next;
                        word_count        <= word_count + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen_32bit.sv
// Directed bench for pattern_gen_32bit with an independent cycle model feeding a scoreboard.
module tb_pattern_gen_32bit;

    typedef struct {
        logic [31:0] data;
        logic [31:0] count;
    } exp_t;

    logic        okClk = 1'b0;
    logic        reset;
    logic [31:0] pattern;
    logic        enable_gener;
    logic [31:0] dataout;
    logic        dataout_available;
    logic [31:0] word_count;
    logic        mode_error;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    int          m_state;
    logic [31:0] m_gen, m_patq, m_count, m_dout;
    logic        m_err, exp_avail;

    pattern_gen_32bit dut (
        .okClk             (okClk),
        .reset             (reset),
        .pattern           (pattern),
        .enable_gener      (enable_gener),
        .dataout           (dataout),
        .dataout_available (dataout_available),
        .word_count        (word_count),
        .mode_error        (mode_error)
    );

    always #5 okClk = ~okClk;

    function automatic logic [31:0] modelSeed(input logic [31:0] pat);
        case (pat[2:0])
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'h0000_0001;
            3'd2:    return {pat[31:16], 16'hACE1};
            3'd3:    return 32'hAAAA_AAAA;
            3'd4:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] modelNext(input logic [2:0] mode, input logic [31:0] cur);
        case (mode)
            3'd0:    return cur + 32'd1;
            3'd1:    return {cur[30:0], cur[31]};
            3'd2:    return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
            3'd3:    return ~cur;
            default: return cur;
        endcase
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checkVal("avail", {31'd0, dataout_available}, {31'd0, exp_avail});
        checkVal("mode_error", {31'd0, mode_error}, {31'd0, m_err});
        checkVal("dataout", dataout, m_dout);
        checkVal("word_count", word_count, m_count);
        if (dataout_available === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("[TB] FAIL sb_empty observed=word %h expected=no word", dataout);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkVal("sb_data", dataout, e.data);
                checkVal("sb_count", word_count, e.count);
            end
        end
    endtask

    // Model advances on the same inputs the DUT sees at the coming edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] pat, input logic en);
        reset        = rst;
        pattern      = pat;
        enable_gener = en;
        exp_avail    = 1'b0;
        if (rst) begin
            m_state = 0; m_gen = '0; m_patq = '0; m_count = '0;
            m_dout  = '0; m_err = 1'b0;
            sb.delete();
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    m_patq  = pat;
                    m_gen   = modelSeed(pat);
                    m_err   = (pat[2:0] > 3'd4);
                    m_state = 2;
                end
                default: begin
                    if (pat !== m_patq) begin
                        m_state = 1;
                    end else if (en && !m_err) begin
                        m_count   = m_count + 32'd1;
                        m_dout    = m_gen;
                        sb.push_back('{data: m_gen, count: m_count});
                        m_gen     = modelNext(m_patq[2:0], m_gen);
                        exp_avail = 1'b1;
                    end
                end
            endcase
        end
        @(posedge okClk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1; pattern = '0; enable_gener = 1'b0;
        m_state = 0; m_gen = '0; m_patq = '0; m_count = '0;
        m_dout = '0; m_err = 1'b0; exp_avail = 1'b0;

        // Counter mode with enable already high: first word after third edge
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0, 1'b1);
        checkVal("reset_count", word_count, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("lat_edge1", {31'd0, dataout_available}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("lat_edge2", {31'd0, dataout_available}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkVal("cnt_data", dataout, i);
            checkVal("cnt_wc", word_count, i + 1);
        end

        // Walking one, full rotation plus wrap
        applyStimulus(1'b1, 32'h1, 1'b0);
        applyStimulus(1'b0, 32'h1, 1'b0);
        applyStimulus(1'b0, 32'h1, 1'b0);
        for (int i = 0; i < 33; i++) begin
            applyStimulus(1'b0, 32'h1, 1'b1);
            checkVal("walk_data", dataout, (i < 32) ? (32'h1 << i) : 32'h1);
        end
        checkVal("walk_wc", word_count, 32'd33);

        // LFSR with seed high half 0x1234
        applyStimulus(1'b1, 32'h1234_0002, 1'b0);
        applyStimulus(1'b0, 32'h1234_0002, 1'b0);
        applyStimulus(1'b0, 32'h1234_0002, 1'b0);
        applyStimulus(1'b0, 32'h1234_0002, 1'b1);
        checkVal("lfsr_w0", dataout, 32'h1234_ACE1);
        applyStimulus(1'b0, 32'h1234_0002, 1'b1);
        checkVal("lfsr_w1", dataout, 32'h2469_59C2);
        for (int i = 0; i < 998; i++) applyStimulus(1'b0, 32'h1234_0002, 1'b1);
        checkVal("lfsr_wc", word_count, 32'd1000);

        // Gapped enable in counter mode
        applyStimulus(1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("gap_d0", dataout, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkVal("gap_a1", {31'd0, dataout_available}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkVal("gap_hold", dataout, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("gap_d3", dataout, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("gap_d4", dataout, 32'd2);

        // Switch to alternating mode at count 5
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkVal("sw_wc5", word_count, 32'd5);
        applyStimulus(1'b0, 32'h3, 1'b1);
        checkVal("sw_detect", {31'd0, dataout_available}, 32'd0);
        applyStimulus(1'b0, 32'h3, 1'b1);
        checkVal("sw_load", {31'd0, dataout_available}, 32'd0);
        applyStimulus(1'b0, 32'h3, 1'b1);
        checkVal("sw_alt0", dataout, 32'hAAAA_AAAA);
        checkVal("sw_wc6", word_count, 32'd6);
        applyStimulus(1'b0, 32'h3, 1'b1);
        checkVal("sw_alt1", dataout, 32'h5555_5555);

        // Reserved mode, then recovery through a valid reload
        applyStimulus(1'b1, 32'h6, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h6, 1'b1);
        checkVal("err_flag", {31'd0, mode_error}, 32'd1);
        checkVal("err_wc", word_count, 32'd0);
        applyStimulus(1'b0, 32'h4, 1'b1);
        applyStimulus(1'b0, 32'h4, 1'b1);
        checkVal("err_clear", {31'd0, mode_error}, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h4, 1'b1);
        checkVal("ones_data", dataout, 32'hFFFF_FFFF);

        // Reset in the middle of a burst
        applyStimulus(1'b1, 32'h4, 1'b1);
        checkVal("mid_rst_dout", dataout, 32'd0);
        checkVal("mid_rst_avail", {31'd0, dataout_available}, 32'd0);
        checkVal("mid_rst_wc", word_count, 32'd0);
        checkVal("mid_rst_err", {31'd0, mode_error}, 32'd0);
        applyStimulus(1'b0, 32'h4, 1'b1);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("[TB] FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
